// File: rtl/clk_enable_divider.sv
// Runtime-programmable clock-enable divider: one-cycle tick per period plus a
// near-50% divided level, with shadowed divisor reload, count gating and phase restart.
module clk_enable_divider #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div,
    input  logic             div_load,
    input  logic             sync,
    output logic             tick,
    output logic             clk_div,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] div_active,
    output logic             pending
);

    localparam int unsigned SW = WIDTH + 1;

    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count_nx;
    logic [WIDTH-1:0] div_nx;
    logic [WIDTH-1:0] shadow_nx;
    logic             pending_nx;
    logic             tick_nx;
    logic             clk_div_nx;
    logic             wrap;
    logic [SW-1:0]    half;

    // Next-state: sync beats counting; the new divisor lands only at a period boundary.
    always_comb begin
        load_val   = (div == '0) ? WIDTH'(1) : div;
        wrap       = en && (count == (div_active - WIDTH'(1)));
        count_nx   = count;
        div_nx     = div_active;
        shadow_nx  = div_load ? load_val : shadow;
        pending_nx = pending;
        tick_nx    = 1'b0;
        clk_div_nx = clk_div;
        half       = '0;

        if (sync || wrap) begin
            count_nx   = '0;
            pending_nx = 1'b0;
            tick_nx    = wrap && !sync;
            if (div_load) begin
                div_nx = load_val;
            end else if (pending) begin
                div_nx = shadow;
            end
        end else begin
            if (en) begin
                count_nx = count + WIDTH'(1);
            end
            if (div_load) begin
                pending_nx = 1'b1;
            end
        end

        // Sum carried in WIDTH+1 bits so the maximum divisor does not overflow.
        half = (SW'(div_nx) + SW'(1)) >> 1;
        if (sync) begin
            clk_div_nx = 1'b0;
        end else if (en) begin
            clk_div_nx = (SW'(count_nx) < half);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            div_active <= WIDTH'(DEFAULT_DIV);
            shadow     <= WIDTH'(DEFAULT_DIV);
            pending    <= 1'b0;
            tick       <= 1'b0;
            clk_div    <= 1'b0;
        end else begin
            count      <= count_nx;
            div_active <= div_nx;
            shadow     <= shadow_nx;
            pending    <= pending_nx;
            tick       <= tick_nx;
            clk_div    <= clk_div_nx;
        end
    end

endmodule

// File: tb/tb_clk_enable_divider.sv
// Self-checking bench for clk_enable_divider: vector table, corner-case sequences
// and randomized traffic against a period-level reference model.
module tb_clk_enable_divider;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEF   = 4;

    logic             clk;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] div;
    logic             div_load;
    logic             sync;
    logic             tick;
    logic             clk_div;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] div_active;
    logic             pending;

    int errors = 0;
    int checks = 0;

    // Reference model state: position in period, period length, queued divisor.
    int m_pos;
    int m_len;
    int m_queued;
    bit m_has_q;
    bit m_tick;

    clk_enable_divider #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .div        (div),
        .div_load   (div_load),
        .sync       (sync),
        .tick       (tick),
        .clk_div    (clk_div),
        .count      (count),
        .div_active (div_active),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // The level is high in the first half of the period, rounding the odd count up.
    function automatic int exp_level();
        return (2 * m_pos < m_len) ? 1 : 0;
    endfunction

    bit m_level;

    task automatic model_edge(input bit e, input int d, input bit l, input bit s, input bit r);
        int req;
        req = (d == 0) ? 1 : d;
        if (r) begin
            m_pos = 0; m_len = DEF; m_has_q = 0; m_tick = 0; m_level = 0;
        end else if (s) begin
            if (l) m_len = req;
            else if (m_has_q) m_len = m_queued;
            m_has_q = 0; m_pos = 0; m_tick = 0; m_level = 0;
        end else if (e) begin
            m_tick = (m_pos + 1 == m_len);
            if (m_tick) begin
                if (l) m_len = req;
                else if (m_has_q) m_len = m_queued;
                m_has_q = 0;
                m_pos = 0;
            end else begin
                m_pos++;
                if (l) begin m_queued = req; m_has_q = 1; end
            end
            m_level = exp_level();
        end else begin
            m_tick = 0;
            if (l) begin m_queued = req; m_has_q = 1; end
        end
    endtask

    task automatic step(input bit e, input int d, input bit l, input bit s, input bit r);
        en = e; div = WIDTH'(d); div_load = l; sync = s; rst = r;
        @(posedge clk);
        model_edge(e, d, l, s, r);
        #1;
        check("model.tick", int'(tick), int'(m_tick));
        check("model.clk_div", int'(clk_div), int'(m_level));
        check("model.count", int'(count), m_pos);
        check("model.div_active", int'(div_active), m_len);
        check("model.pending", int'(pending), int'(m_has_q));
    endtask

    task automatic run_until_tick(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            step(1, 0, 0, 0, 0);
            n++;
            if (tick) break;
        end
        if (!tick) check("tick_timeout", 0, 1);
    endtask

    typedef struct {
        bit en; int dv; bit ld; bit sy; bit rs;
        bit t; bit cd; int c; int d; bit p;
    } vec_t;

    vec_t vq[$];

    initial begin
        int n;
        int first_t;
        int hi;
        int tk;
        int tick_at[$];

        rst = 1; en = 0; div = '0; div_load = 0; sync = 0;
        m_pos = 0; m_len = DEF; m_queued = DEF; m_has_q = 0; m_tick = 0; m_level = 0;

        // en dv ld sy rs | tick clk_div count div_active pending
        vq.push_back('{0, 0, 0, 0, 1, 0, 0, 0, 4, 0});
        vq.push_back('{1, 0, 0, 0, 0, 0, 1, 1, 4, 0});
        vq.push_back('{1, 0, 0, 0, 0, 0, 0, 2, 4, 0});
        vq.push_back('{1, 0, 0, 0, 0, 0, 0, 3, 4, 0});
        vq.push_back('{1, 0, 0, 0, 0, 1, 1, 0, 4, 0});
        vq.push_back('{1, 0, 0, 0, 0, 0, 1, 1, 4, 0});
        vq.push_back('{1, 5, 1, 0, 0, 0, 0, 2, 4, 1});
        vq.push_back('{1, 0, 0, 0, 0, 0, 0, 3, 4, 1});
        vq.push_back('{1, 0, 0, 0, 0, 1, 1, 0, 5, 0});
        vq.push_back('{1, 0, 0, 0, 0, 0, 1, 1, 5, 0});
        vq.push_back('{1, 0, 0, 0, 0, 0, 1, 2, 5, 0});
        vq.push_back('{1, 0, 0, 0, 0, 0, 0, 3, 5, 0});
        vq.push_back('{1, 0, 0, 0, 0, 0, 0, 4, 5, 0});
        vq.push_back('{1, 0, 0, 0, 0, 1, 1, 0, 5, 0});
        vq.push_back('{1, 0, 0, 0, 0, 0, 1, 1, 5, 0});
        vq.push_back('{1, 0, 0, 0, 0, 0, 1, 2, 5, 0});
        vq.push_back('{1, 0, 0, 0, 0, 0, 0, 3, 5, 0});
        vq.push_back('{1, 0, 0, 0, 0, 0, 0, 4, 5, 0});
        vq.push_back('{1, 7, 1, 0, 0, 1, 1, 0, 7, 0});
        vq.push_back('{1, 0, 0, 0, 0, 0, 1, 1, 7, 0});
        vq.push_back('{1, 0, 0, 0, 0, 0, 1, 2, 7, 0});
        vq.push_back('{1, 0, 0, 1, 0, 0, 0, 0, 7, 0});
        vq.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 7, 0});
        vq.push_back('{1, 0, 0, 0, 0, 0, 1, 1, 7, 0});

        foreach (vq[i]) begin
            step(vq[i].en, vq[i].dv, vq[i].ld, vq[i].sy, vq[i].rs);
            check("vec.tick", int'(tick), int'(vq[i].t));
            check("vec.clk_div", int'(clk_div), int'(vq[i].cd));
            check("vec.count", int'(count), vq[i].c);
            check("vec.div_active", int'(div_active), vq[i].d);
            check("vec.pending", int'(pending), int'(vq[i].p));
        end

        // Gating: divisor 3, en alternating, ticks 6 clocks apart.
        step(1, 3, 1, 1, 0);
        for (int i = 0; i < 16; i++) begin
            step((i % 2) == 0, 0, 0, 0, 0);
            if (tick) tick_at.push_back(i);
        end
        check("gate.tick_count", tick_at.size(), 2);
        if (tick_at.size() >= 2) check("gate.spacing", tick_at[1] - tick_at[0], 6);

        // Phase restart at count 2.
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("sync.pre_count", int'(count), 2);
        step(1, 0, 0, 1, 0);
        check("sync.count", int'(count), 0);
        check("sync.tick", int'(tick), 0);
        run_until_tick(n);
        check("sync.next_tick", n, 3);

        // Divisor 0 coerces to 1: continuous tick after the wrap.
        step(1, 0, 1, 0, 0);
        check("div0.pending", int'(pending), 1);
        run_until_tick(n);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 0);
            check("div0.tick", int'(tick), 1);
            check("div0.div_active", int'(div_active), 1);
        end

        // Maximum divisor.
        step(1, 255, 1, 1, 0);
        hi = 0; tk = 0; first_t = -1;
        for (int i = 0; i < 255; i++) begin
            step(1, 0, 0, 0, 0);
            hi += int'(clk_div);
            tk += int'(tick);
            if (tick && first_t < 0) first_t = i + 1;
        end
        check("max.ticks", tk, 1);
        check("max.period", first_t, 255);
        check("max.high", hi, 128);

        // Reset mid-period with a pending divisor.
        step(1, 6, 1, 1, 0);
        step(1, 0, 0, 0, 0);
        step(1, 9, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("rstmid.pre_count", int'(count), 4);
        check("rstmid.pre_pending", int'(pending), 1);
        check("rstmid.pre_div", int'(div_active), 6);
        step(1, 0, 0, 0, 1);
        check("rstmid.count", int'(count), 0);
        check("rstmid.div_active", int'(div_active), 4);
        check("rstmid.pending", int'(pending), 0);
        check("rstmid.tick", int'(tick), 0);
        check("rstmid.clk_div", int'(clk_div), 0);
        run_until_tick(n);
        check("rstmid.first_tick", n, 4);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(3, 0) != 0,
                 ($urandom_range(7, 0) == 0) ? int'($urandom_range(255, 0)) : int'($urandom_range(9, 0)),
                 $urandom_range(9, 0) == 0,
                 $urandom_range(39, 0) == 0,
                 $urandom_range(199, 0) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_enable_divider.md
Name: clk_enable_divider

Overview:
- Parametrised, runtime-programmable clock-enable divider. It is the successor to the single-bit toggle-flop divider stage.
- Produces a one-cycle `tick` enable every `div_active` enabled cycles, plus a near-50% duty divided level `clk_div`. Both are in the `clk` domain; neither is used as a real clock.
- Feeds the VGA pixel-rate enable and other slow-rate enables. Supports glitch-free divisor change, count gating and phase restart.

Parameters:
- WIDTH, 8, counter and divisor width in bits; legal divisors are 1 .. 2^WIDTH-1.
- DEFAULT_DIV, 4, divisor active after reset; must satisfy 1 <= DEFAULT_DIV <= 2^WIDTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; counter advances only on edges where en=1.
- div  input  WIDTH  requested divisor, sampled when div_load=1.
- div_load  input  1  single-cycle request to load div.
- sync  input  1  phase restart; acts regardless of en.
- tick  output  1  one-cycle pulse at each period wrap.
- clk_div  output  1  divided level, high for the first ceil(div_active/2) counts of each period.
- count  output  WIDTH  current counter value (0 .. div_active-1).
- div_active  output  WIDTH  divisor currently in effect.
- pending  output  1  a loaded divisor is waiting for the next wrap.

Behaviour:
- All outputs are registered. No combinational path from any input to any output.
- Reset (rst=1 at a rising edge) sets:
  - count=0, div_active=DEFAULT_DIV, pending=0, tick=0, clk_div=0.
  - The pending divisor is discarded.
- Priority at each edge: rst > sync > en/wrap. div_load is captured in every non-reset cycle.
- wrap condition: en=1 and count==div_active-1.
- Count (en=1, no sync):
  - count <= wrap ? 0 : count+1.
  - tick <= wrap.
  - clk_div <= (next_count < (div_active_next+1)/2), where the division is an integer shift of a WIDTH+1 bit sum, so there is no overflow at the max divisor.
- en=0 (no sync): count, clk_div and div_active hold; tick <= 0.
- Period: tick is high for exactly 1 cycle per div_active enabled edges. The first tick after reset appears on the DEFAULT_DIV-th enabled edge.
- div_active==1: count stays 0; tick=1 and clk_div=1 on every enabled edge, so tick is continuously high while en=1.
- Divisor load:
  - On div_load=1, the value div (with 0 coerced to 1) goes into a shadow register and pending <= 1.
  - A repeated load before the wrap overwrites the shadow register; the last value wins.
  - At the wrap edge, div_active <= shadow and pending <= 0. The wrap compare on that edge uses the old div_active; the new period runs at the new value.
  - If div_load and wrap fall on the same edge, the incoming div is applied directly at that edge and pending stays 0.
- sync=1:
  - count <= 0, tick <= 0, clk_div <= 0.
  - Any pending divisor (or a div_load on the same edge) is applied immediately; pending <= 0.
  - The next period starts from count 0. The first tick comes div_active enabled edges later.
- Runtime divisor change never produces a tick shorter than one cycle, a double tick, or a count >= div_active.
- Reset mid-period behaves exactly as the reset case above; no partial state survives.

Test Plan:
- Reset release, en=1 constantly, DEFAULT_DIV=4:
  - First tick on 4th edge, then every 4 cycles.
  - clk_div pattern per period: count 1,2,3,0 -> 1,0,0,1, i.e. 2 high / 2 low steady state.
  - div_active=4.
- div_load with div=5 at count=1, div_active=4:
  - pending=1 until the wrap; that wrap is 4 cycles after the previous one.
  - Then div_active=5 and ticks are every 5 cycles.
  - clk_div high for 3 of 5 cycles.
- Gating and phase restart:
  - en toggled 1,0,1,0 with div_active=3: tick spacing is 3 enabled edges (6 clocks); count holds during en=0.
  - sync at count=2: next edge count=0, tick=0; next tick 3 enabled edges later.
- Edge-case loads:
  - div_load with div=0: div_active becomes 1 at the next wrap, after which tick is continuously high while en=1.
  - div_load coincident with wrap, div=7: div_active=7 that edge, pending=0.
  - With WIDTH=8, div=255: period is 255 cycles, clk_div high for 128 cycles.
- Reset mid-period:
  - Setup: div_active=6, pending=1, count=4.
  - Required response after the rst edge: count=0, div_active=4, pending=0, tick=0, clk_div=0.
  - First tick is 4 enabled edges after rst deasserts.
